// File: rtl/calc_key_entry.sv
// calc_key_entry: keypad entry controller in front of the calculator core.
// Collects decimal key presses into two operands and an operation code and
// drives them to the arithmetic core. On "=" it raises calc_valid for one
// cycle, and captures the core result for display and for chaining into
// the next expression.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   key_valid         a key event is present this cycle
//   key_code          0-9 digit, 10 mul, 11 add, 12 sub, 13 equals,
//                     14 clear, 15 reserved
//   result_in         core result (combinational from the operands)
//   first_digit       operand A to the core
//   second_digit      operand B to the core
//   operation         00 mul, 01 add, 10 sub
//   calc_valid        one-cycle strobe: expression complete, result_in valid
//   disp_value        value to show (entry in progress or result)
//   entry_state       current FSM state
//
// state    | meaning
// ENTER_A  | typing operand A
// OP_SEL   | operator chosen, waiting for the first digit of B
// ENTER_B  | typing operand B
// DONE     | expression evaluated, result captured
module calc_key_entry #(
  parameter int W          = 14,
  parameter int MAX_DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic [W-1:0] result_in,
  output logic [W-1:0] first_digit,
  output logic [W-1:0] second_digit,
  output logic [1:0]   operation,
  output logic         calc_valid,
  output logic [W-1:0] disp_value,
  output logic [1:0]   entry_state
);

  localparam logic [1:0] ENTER_A = 2'b00;
  localparam logic [1:0] OP_SEL  = 2'b01;
  localparam logic [1:0] ENTER_B = 2'b10;
  localparam logic [1:0] DONE    = 2'b11;

  localparam int            CW  = $clog2(MAX_DIGITS + 1);
  localparam logic [W-1:0]  TEN = W'(10);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          valid_q, valid_d;

  logic          is_digit, is_op, is_eq, is_clr, cnt_full;
  logic [1:0]    key_op;
  logic [W-1:0]  digit;
  logic [W-1:0]  res_cur;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_eq    = (key_code == 4'd13);
  assign is_clr   = (key_code == 4'd14);
  assign cnt_full = (cnt_q == CNT_MAX);
  assign digit    = {{(W-4){1'b0}}, key_code};

  always_comb begin
    case (key_code)
      4'd10:   key_op = 2'b00;
      4'd11:   key_op = 2'b01;
      default: key_op = 2'b10;
    endcase
  end

  // In the strobe cycle the result register has not been loaded yet, so the
  // live core result stands in for it (display and chaining alike).
  assign res_cur = valid_q ? result_in : res_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = valid_q ? result_in : res_q;
    valid_d = 1'b0;
    if (key_valid) begin
      if (is_clr) begin
        state_d = ENTER_A;
        a_d     = '0;
        b_d     = '0;
        op_d    = 2'b00;
        cnt_d   = '0;
        res_d   = '0;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (is_digit && !cnt_full) begin
              a_d   = a_q * TEN + digit;
              cnt_d = cnt_q + 1'b1;
            end else if (is_op) begin
              op_d    = key_op;
              b_d     = '0;
              cnt_d   = '0;
              state_d = OP_SEL;
            end
          end
          OP_SEL: begin
            if (is_op) begin
              op_d = key_op;
            end else if (is_digit) begin
              b_d     = digit;
              cnt_d   = CW'(1);
              state_d = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit && !cnt_full) begin
              b_d   = b_q * TEN + digit;
              cnt_d = cnt_q + 1'b1;
            end else if (is_eq) begin
              valid_d = 1'b1;
              state_d = DONE;
            end
          end
          default: begin
            if (is_digit) begin
              a_d     = digit;
              b_d     = '0;
              cnt_d   = CW'(1);
              state_d = ENTER_A;
            end else if (is_op) begin
              a_d     = res_cur;
              b_d     = '0;
              op_d    = key_op;
              cnt_d   = '0;
              state_d = OP_SEL;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_B: disp_value = b_q;
      DONE:    disp_value = res_cur;
      default: disp_value = a_q;
    endcase
  end

  assign first_digit  = a_q;
  assign second_digit = b_q;
  assign operation    = op_q;
  assign calc_valid   = valid_q;
  assign entry_state  = state_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry with a behavioural model of the core.
module tb_calc_key_entry;

  localparam int W = 14;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] result_in;
  logic [W-1:0] first_digit;
  logic [W-1:0] second_digit;
  logic [1:0]   operation;
  logic         calc_valid;
  logic [W-1:0] disp_value;
  logic [1:0]   entry_state;

  int total;
  int bad;

  calc_key_entry #(.W(W), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .result_in    (result_in),
    .first_digit  (first_digit),
    .second_digit (second_digit),
    .operation    (operation),
    .calc_valid   (calc_valid),
    .disp_value   (disp_value),
    .entry_state  (entry_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arithmetic core model
  always_comb begin
    case (operation)
      2'b00:   result_in = W'(first_digit * second_digit);
      2'b01:   result_in = W'(first_digit + second_digit);
      default: result_in = W'(first_digit - second_digit);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one key pulse; returns on the following falling edge with results visible
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    #2;
    check("rst_a", first_digit, 0);
    check("rst_b", second_digit, 0);
    check("rst_op", operation, 0);
    check("rst_valid", calc_valid, 0);
    check("rst_disp", disp_value, 0);
    check("rst_state", entry_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // case 1: 12 + 34 =
    press(4'd13);
    check("eq_in_a_ignored_state", entry_state, 0);
    check("eq_in_a_ignored_valid", calc_valid, 0);
    press(4'd1);
    press(4'd2);
    check("c1_disp_a", disp_value, 12);
    press(4'd11);
    check("c1_state_opsel", entry_state, 1);
    check("c1_disp_opsel", disp_value, 12);
    press(4'd3);
    press(4'd15);
    check("c1_reserved_b", second_digit, 3);
    press(4'd4);
    check("c1_disp_b", disp_value, 34);
    press(4'd10);
    check("c1_op_in_b_ignored", operation, 1);
    check("c1_op_in_b_state", entry_state, 2);
    press(4'd13);
    check("c1_a", first_digit, 12);
    check("c1_b", second_digit, 34);
    check("c1_op", operation, 1);
    check("c1_valid", calc_valid, 1);
    check("c1_disp", disp_value, 46);
    check("c1_state", entry_state, 3);
    idle();
    check("c1_valid_drop", calc_valid, 0);
    check("c1_disp_held", disp_value, 46);

    // case 4: chain * 2 =
    press(4'd10);
    check("c4_a_chain", first_digit, 46);
    check("c4_b_zero", second_digit, 0);
    check("c4_op", operation, 0);
    check("c4_state", entry_state, 1);
    press(4'd2);
    press(4'd13);
    check("c4_valid", calc_valid, 1);
    check("c4_disp", disp_value, 92);
    press(4'd13);
    check("c4_no_second_pulse", calc_valid, 0);
    check("c4_disp_held", disp_value, 92);

    // case 2: digit limit, starting from DONE
    press(4'd14);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    check("c2_a", first_digit, 1234);
    check("c2_state", entry_state, 0);

    // case 3: operator replacement, 7 - 2
    press(4'd14);
    press(4'd7);
    press(4'd10);
    press(4'd12);
    check("c3_op_replaced", operation, 2);
    press(4'd2);
    press(4'd13);
    check("c3_b", second_digit, 2);
    check("c3_valid", calc_valid, 1);
    check("c3_disp", disp_value, 5);
    idle();
    check("c3_valid_once", calc_valid, 0);

    // digit in DONE starts fresh entry
    press(4'd8);
    check("done_digit_a", first_digit, 8);
    check("done_digit_b", second_digit, 0);
    check("done_digit_state", entry_state, 0);

    // case 5: clear mid-entry
    press(4'd14);
    press(4'd5);
    press(4'd11);
    press(4'd6);
    press(4'd14);
    check("c5_a", first_digit, 0);
    check("c5_b", second_digit, 0);
    check("c5_op", operation, 0);
    check("c5_state", entry_state, 0);
    press(4'd9);
    check("c5_a_after", first_digit, 9);

    // case 6: reset during ENTER_B
    press(4'd14);
    press(4'd1);
    press(4'd11);
    press(4'd4);
    press(4'd2);
    check("c6_b_before", second_digit, 42);
    #1 rst_n = 1'b0;
    #1;
    check("c6_a", first_digit, 0);
    check("c6_b", second_digit, 0);
    check("c6_op", operation, 0);
    check("c6_disp", disp_value, 0);
    check("c6_state", entry_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd3);
    check("c6_a_after", first_digit, 3);

    // reset during the strobe cycle kills the pulse
    press(4'd11);
    press(4'd2);
    press(4'd13);
    check("rv_valid_before", calc_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rv_valid_killed", calc_valid, 0);
    check("rv_disp", disp_value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("rv_state", entry_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
Keypad entry controller sitting directly upstream of the calculator arithmetic core. It accumulates decimal key presses into two 14-bit operands and a 2-bit operation code, then drives the core's first_digit, second_digit and operation inputs. On "=" it presents the completed expression with a one-cycle strobe. It captures the core's combinational result for display and for chaining into the next expression.

Parameters:
W, 14, operand/result width; must match the arithmetic core.
MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS-1 must fit in W bits.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one key event per cycle while high; upstream delivers debounced single-cycle pulses
key_code  in  4  0-9 digit; 10 mul; 11 add; 12 sub; 13 equals; 14 clear; 15 reserved
result_in  in  W  arithmetic core result (combinational from first_digit/second_digit/operation)
first_digit  out  W  operand A to core, registered
second_digit  out  W  operand B to core, registered
operation  out  2  00 mul, 01 add, 10 sub; 11 never driven
calc_valid  out  1  one-cycle pulse: operands/operation complete, result_in valid this cycle
disp_value  out  W  value to display: entry in progress or captured result
entry_state  out  2  current FSM state encoding (for display/debug)

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0, state ENTER_A, digit counter 0, captured result 0.
- All updates on rising clk when key_valid=1; key effects visible after that edge (1-cycle latency). key_valid=0: hold everything; calc_valid returns to 0.
- States (entry_state): ENTER_A=00, OP_SEL=01, ENTER_B=10, DONE=11.
- Digit append: value <= value*10 + d, counter++; if counter==MAX_DIGITS the digit is ignored (no change).
- ENTER_A: digit -> append to first_digit. Operator -> latch operation, go OP_SEL. Equals -> ignored.
- OP_SEL: operator -> replace operation, stay. Digit -> second_digit <= d, counter=1, go ENTER_B. Equals -> ignored.
- ENTER_B: digit -> append to second_digit. Operator -> ignored. Equals -> go DONE, calc_valid=1 for exactly the following cycle.
- DONE: result_in captured into result register during the cycle calc_valid=1. Digit -> first_digit <= d, second_digit <= 0, counter=1, go ENTER_A. Operator -> first_digit <= captured result, second_digit <= 0, latch operation, go OP_SEL (chaining). Equals -> ignored (no second strobe).
- Clear (14) in any state: operands, operation, counter, captured result -> 0; go ENTER_A; calc_valid cleared.
- Reserved code 15: ignored in all states.
- Entering OP_SEL from ENTER_A: second_digit forced to 0, counter reset to 0.
- disp_value: ENTER_A -> first_digit; OP_SEL -> first_digit; ENTER_B -> second_digit; DONE -> captured result (result_in in the calc_valid cycle).
- Arithmetic: entry values never exceed 10^MAX_DIGITS-1; chained first_digit may be any W-bit value (incl. wrapped subtraction); held unmodified.
- Reset asserted mid-entry or during calc_valid: immediate return to reset values; no pulse completes.

Test Plan:
1. Keys 1,2,+,3,4,= -> first_digit=12, second_digit=34, operation=01, calc_valid high exactly 1 cycle, disp_value=46 in DONE.
2. Keys 1,2,3,4,5 -> first_digit=1234; fifth digit ignored, entry_state=00.
3. Keys 7,*,-,2,= -> operation=10 (replacement), second_digit=2, calc_valid once, disp_value=5.
4. Chaining: after case 1, keys *,2,= -> first_digit=46, operation=00, second_digit=2, disp_value=92; extra "=" gives no further pulse.
5. Keys 5,+,6, clear -> all operands 0, operation 00, entry_state 00; then 9 -> first_digit=9.
6. rst_n low for 1 cycle during ENTER_B with second_digit=42 -> all outputs 0 immediately, entry_state 00; key 3 afterwards -> first_digit=3.
